// File: rtl/mult_seq_pkg.sv
// Shared definitions for the repeated-addition multiplier sequencer.
package mult_seq_pkg;

  localparam int unsigned MULT_WIDTH   = 16;
  localparam int unsigned MULT_TIMEOUT = 70000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } seq_state_e;

endpackage

// File: rtl/mult_seq_timer.sv
// Watchdog counter: clears on clr, counts while en, saturates at TIMEOUT-1.
module mult_seq_timer
  import mult_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT = MULT_TIMEOUT
) (
  input  logic clk,
  input  logic res_n,
  input  logic clr,
  input  logic en,
  output logic expire_c
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q;

  // Cycle counter; holds at LAST so it can never wrap back to zero.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en && (count_q != LAST)) begin
      count_q <= count_q + CW'(1);
    end
  end

  assign expire_c = (count_q == LAST);

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequencer: feeds operand pairs to the multiplier, collects the product,
// and aborts with a timeout flag if done never arrives.
module mult_seq_ctrl
  import mult_seq_pkg::*;
#(
  parameter int unsigned WIDTH   = MULT_WIDTH,
  parameter int unsigned TIMEOUT = MULT_TIMEOUT
) (
  input  logic               clk,
  input  logic               res_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [WIDTH-1:0]   req_a,
  input  logic [WIDTH-1:0]   req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2*WIDTH-1:0] rsp_product,
  output logic               rsp_timeout,
  output logic               busy,
  output logic               mul_res_n,
  output logic               mul_start,
  output logic [WIDTH-1:0]   mul_arg1,
  output logic [WIDTH-1:0]   mul_arg2,
  input  logic               mul_done,
  input  logic [2*WIDTH-1:0] mul_product
);

  localparam int unsigned PW = 2 * WIDTH;

  seq_state_e       state_q, state_d;
  logic [WIDTH-1:0] arg1_d, arg2_d;
  logic [PW-1:0]    prod_d;
  logic             tout_d;
  logic             accept_c;
  logic             expire_c;

  // req_ready is only high in IDLE, so this is the handshake.
  assign accept_c = req_valid & req_ready;

  mult_seq_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .res_n    (res_n),
    .clr      (state_q == ST_START),
    .en       (state_q == ST_WAIT),
    .expire_c (expire_c)
  );

  // Next state and next values of the latched operands/result.
  always_comb begin
    state_d = state_q;
    arg1_d  = mul_arg1;
    arg2_d  = mul_arg2;
    prod_d  = rsp_product;
    tout_d  = rsp_timeout;
    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          arg1_d  = req_a;
          arg2_d  = req_b;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: state_d = ST_START;
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        // done has priority over a coincident expiry
        if (mul_done) begin
          prod_d  = mul_product;
          tout_d  = 1'b0;
          state_d = ST_RESP;
        end else if (expire_c) begin
          prod_d  = '0;
          tout_d  = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Registered outputs decoded from the upcoming state; multiplier held in reset during res_n.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_product <= '0;
      rsp_timeout <= 1'b0;
      busy        <= 1'b0;
      mul_res_n   <= 1'b0;
      mul_start   <= 1'b0;
      mul_arg1    <= '0;
      mul_arg2    <= '0;
    end else begin
      req_ready   <= (state_d == ST_IDLE);
      rsp_valid   <= (state_d == ST_RESP);
      rsp_product <= prod_d;
      rsp_timeout <= tout_d;
      busy        <= (state_d != ST_IDLE);
      mul_res_n   <= (state_d != ST_CLEAR);
      mul_start   <= (state_d == ST_START);
      mul_arg1    <= arg1_d;
      mul_arg2    <= arg2_d;
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Randomized self-checking bench for mult_seq_ctrl with a behavioural multiplier.
module tb_mult_seq_ctrl;

  localparam int unsigned W  = 16;
  localparam int unsigned TO = 20;

  logic           clk = 1'b0;
  logic           res_n;
  logic           req_valid;
  logic           req_ready;
  logic [W-1:0]   req_a;
  logic [W-1:0]   req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [2*W-1:0] rsp_product;
  logic           rsp_timeout;
  logic           busy;
  logic           mul_res_n;
  logic           mul_start;
  logic [W-1:0]   mul_arg1;
  logic [W-1:0]   mul_arg2;
  logic           mul_done;
  logic [2*W-1:0] mul_product;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mult_seq_ctrl #(
    .WIDTH   (W),
    .TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .res_n       (res_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_product (rsp_product),
    .rsp_timeout (rsp_timeout),
    .busy        (busy),
    .mul_res_n   (mul_res_n),
    .mul_start   (mul_start),
    .mul_arg1    (mul_arg1),
    .mul_arg2    (mul_arg2),
    .mul_done    (mul_done),
    .mul_product (mul_product)
  );

  // Multiplier model: done is first high in WAIT cycle number done_at (0 = never).
  int unsigned done_at = 0;
  int unsigned mcnt;
  logic        running;

  always @(posedge clk) begin
    if (!mul_res_n) begin
      mul_done    <= 1'b0;
      running     <= 1'b0;
      mcnt        <= 0;
      mul_product <= '0;
    end else if (mul_start) begin
      running     <= 1'b1;
      mcnt        <= 1;
      mul_done    <= (done_at == 1);
      mul_product <= (2*W)'(mul_arg1) * (2*W)'(mul_arg2);
    end else if (running) begin
      mcnt <= mcnt + 1;
      if (done_at != 0 && mcnt + 1 == done_at) mul_done <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One full transaction: request, watch the multiplier handshake, then drain the response.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input int unsigned dat, input int unsigned bp, input bit poke);
    int unsigned      k;
    logic [2*W-1:0]   ep;
    logic             et;
    int               c;
    bit               seen;
    if (dat != 0 && dat <= TO) begin
      k  = dat;
      ep = (2*W)'(a) * (2*W)'(b);
      et = 1'b0;
    end else begin
      k  = TO;
      ep = '0;
      et = 1'b1;
    end
    done_at = dat;
    @(negedge clk);
    check("req_ready_idle", 64'(req_ready), 64'(1));
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    @(negedge clk);
    req_valid = 1'b0;
    req_a     = W'($urandom);
    req_b     = W'($urandom);
    c    = 1;
    seen = 1'b0;
    while (!seen && c <= int'(TO) + 8) begin
      if (rsp_valid) begin
        seen = 1'b1;
      end else begin
        if (c <= 3) begin
          check("mul_res_n_seq", 64'(mul_res_n), 64'(c != 1));
          check("mul_start_seq", 64'(mul_start), 64'(c == 2));
        end
        check("busy_op", 64'(busy), 64'(1));
        check("arg1_hold", 64'(mul_arg1), 64'(a));
        check("arg2_hold", 64'(mul_arg2), 64'(b));
        @(negedge clk);
        c++;
      end
    end
    check("rsp_seen", 64'(seen), 64'(1));
    check("rsp_latency", 64'(c), 64'(3 + k));
    check("rsp_product", 64'(rsp_product), 64'(ep));
    check("rsp_timeout", 64'(rsp_timeout), 64'(et));
    for (int i = 0; i < int'(bp); i++) begin
      req_valid = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      check("bp_valid", 64'(rsp_valid), 64'(1));
      check("bp_product", 64'(rsp_product), 64'(ep));
      check("bp_timeout", 64'(rsp_timeout), 64'(et));
      check("bp_req_ready", 64'(req_ready), 64'(0));
      check("bp_no_start", 64'(mul_start), 64'(0));
      check("bp_arg1", 64'(mul_arg1), 64'(a));
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("post_rsp_valid", 64'(rsp_valid), 64'(0));
    check("post_req_ready", 64'(req_ready), 64'(1));
    check("post_busy", 64'(busy), 64'(0));
  endtask

  initial begin
    res_n     = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    req_a     = '0;
    req_b     = '0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_mul_res_n", 64'(mul_res_n), 64'(0));
    check("rst_mul_start", 64'(mul_start), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    res_n = 1'b1;
    #1;
    check("rel_req_ready_now", 64'(req_ready), 64'(0));
    @(negedge clk);
    check("rel_req_ready_next", 64'(req_ready), 64'(1));
    check("rel_mul_res_n", 64'(mul_res_n), 64'(1));

    do_op(16'd3, 16'd5, 6, 2, 1'b0);
    do_op(16'd9, 16'd11, 4, 10, 1'b1);
    do_op(16'd100, 16'd200, 0, 1, 1'b0);
    do_op(16'd100, 16'd200, TO, 1, 1'b0);
    do_op(16'd100, 16'd200, TO + 1, 1, 1'b0);
    do_op(16'hFFFF, 16'hFFFF, 3, 0, 1'b0);
    do_op(16'd7, 16'd0, 2, 0, 1'b0);
    do_op(16'd1234, 16'd1, 1, 0, 1'b0);

    // Reset in the middle of WAIT.
    done_at = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_a     = 16'd55;
    req_b     = 16'd66;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (6) @(negedge clk);
    res_n = 1'b0;
    #1;
    check("mid_rst_req_ready", 64'(req_ready), 64'(0));
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("mid_rst_mul_res_n", 64'(mul_res_n), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_arg1", 64'(mul_arg1), 64'(0));
    @(negedge clk);
    res_n = 1'b1;
    @(negedge clk);
    check("mid_rel_req_ready", 64'(req_ready), 64'(1));
    do_op(16'd2, 16'd2, 3, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      do_op(W'($urandom), W'($urandom), $urandom_range(0, TO + 3),
            $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
